// File: rtl/signal_demultiplexer.sv
// -----------------------------------------------------------------------------
// signal_demultiplexer
//
// Receive side of the 4-bit time-division pin link. It collects a stream of
// nibbles into N_signals parallel 16-bit words. A frame is F = 4*N_signals
// nibbles long, and frame_sync marks its first nibble. Nibbles go into a
// shadow register. The published word changes only once the last nibble of a
// frame arrives, so consumers never see a partial frame.
//
// Ports
//   clk          sole clock, rising edge
//   reset        asynchronous, active-high; clears all state
//   mux_in[3:0]  nibble from the pin bus
//   in_valid     qualifies mux_in / frame_sync
//   frame_sync   accepted nibble is the first of a frame
//   signals      last complete frame; signal i at [16i+15:16i]
//   frame_valid  one-cycle pulse when signals updates
//   sync_error   one-cycle pulse on a framing violation
//   locked       high while receiving (RECV state)
//   frame_count  completed frames since reset, wraps at 16 bits
// -----------------------------------------------------------------------------
module signal_demultiplexer #(
    parameter int N_signals = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             mux_in,
    input  logic                   in_valid,
    input  logic                   frame_sync,
    output logic [16*N_signals-1:0] signals,
    output logic                   frame_valid,
    output logic                   sync_error,
    output logic                   locked,
    output logic [15:0]            frame_count
);

    localparam int F     = 4 * N_signals;
    localparam int IDX_W = (F > 1) ? $clog2(F) : 1;
    localparam int W     = 16 * N_signals;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(F - 1);

    typedef enum logic {HUNT, RECV} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     signals_q, signals_d;
    logic             frame_valid_q, frame_valid_d;
    logic             sync_error_q, sync_error_d;
    logic [15:0]      frame_count_q, frame_count_d;

    // Nibble write request for this cycle and its slot index.
    logic             wr_en;
    logic [IDX_W-1:0] wr_slot;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        signals_d     = signals_q;
        frame_valid_d = 1'b0;
        sync_error_d  = 1'b0;
        frame_count_d = frame_count_q;
        wr_en         = 1'b0;
        wr_slot       = '0;

        if (in_valid) begin
            if (frame_sync) begin
                // A sync always starts a new frame. Any partial frame in
                // progress is abandoned, and that is a framing error.
                if (state_q == RECV && idx_q != '0) begin
                    sync_error_d = 1'b1;
                end
                state_d = RECV;
                wr_en   = 1'b1;
                wr_slot = '0;
            end else if (state_q == RECV) begin
                if (idx_q == '0) begin
                    // A frame boundary was expected but no sync came.
                    sync_error_d = 1'b1;
                    state_d      = HUNT;
                end else begin
                    wr_en   = 1'b1;
                    wr_slot = idx_q;
                end
            end
            // In HUNT, nibbles without sync are dropped.
        end

        if (wr_en) begin
            shadow_d[{wr_slot, 2'b00} +: 4] = mux_in;
            if (wr_slot == LAST_IDX) begin
                // Publish the merged shadow as a single atomic update.
                signals_d     = shadow_d;
                frame_valid_d = 1'b1;
                frame_count_d = frame_count_q + 16'd1;
                idx_d         = '0;
            end else begin
                idx_d = wr_slot + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HUNT;
            idx_q         <= '0;
            shadow_q      <= '0;
            signals_q     <= '0;
            frame_valid_q <= 1'b0;
            sync_error_q  <= 1'b0;
            frame_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            signals_q     <= signals_d;
            frame_valid_q <= frame_valid_d;
            sync_error_q  <= sync_error_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign signals     = signals_q;
    assign frame_valid = frame_valid_q;
    assign sync_error  = sync_error_q;
    assign locked      = (state_q == RECV);
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_signal_demultiplexer.sv
// -----------------------------------------------------------------------------
// tb_signal_demultiplexer
//
// Drives nibble streams into signal_demultiplexer. The streams are a set of
// directed scenarios followed by randomized frames, gaps and framing faults.
// A reference model tracks the expected state: a queue of nibbles received
// for the current frame, a lock flag and the last published word. Every DUT
// output is compared against that model after each clock edge.
// -----------------------------------------------------------------------------
module tb_signal_demultiplexer;

    localparam int N = 4;
    localparam int F = 4 * N;
    localparam int W = 16 * N;

    typedef logic [3:0] frame_t [F];

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [3:0]   mux_in = 4'h0;
    logic         in_valid = 1'b0;
    logic         frame_sync = 1'b0;
    logic [W-1:0] signals;
    logic         frame_valid;
    logic         sync_error;
    logic         locked;
    logic [15:0]  frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit           m_locked;
    int           m_q[$];
    logic [W-1:0] m_signals;
    bit           m_fv;
    bit           m_err;
    logic [15:0]  m_count;

    signal_demultiplexer #(.N_signals(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .mux_in      (mux_in),
        .in_valid    (in_valid),
        .frame_sync  (frame_sync),
        .signals     (signals),
        .frame_valid (frame_valid),
        .sync_error  (sync_error),
        .locked      (locked),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked  = 0;
        m_q.delete();
        m_signals = '0;
        m_fv      = 0;
        m_err     = 0;
        m_count   = 16'd0;
    endtask

    // Apply one accepted (or idle) cycle to the model.
    task automatic model_step(input bit v, input bit s, input logic [3:0] nib);
        logic [W-1:0] word;
        m_fv  = 0;
        m_err = 0;
        if (!v) return;
        if (s) begin
            if (m_locked && m_q.size() != 0) m_err = 1;
            m_q.delete();
            m_q.push_back(int'(nib));
            m_locked = 1;
        end else if (!m_locked) begin
            return;
        end else if (m_q.size() == 0) begin
            m_err    = 1;
            m_locked = 0;
            return;
        end else begin
            m_q.push_back(int'(nib));
        end
        if (m_q.size() == F) begin
            word = '0;
            for (int n = 0; n < F; n++) word = word | (W'(m_q[n]) << (4 * n));
            m_signals = word;
            m_fv      = 1;
            m_count   = m_count + 16'd1;
            m_q.delete();
        end
    endtask

    task automatic check_all();
        check_val("signals", signals, m_signals);
        check_val("frame_valid", 64'(frame_valid), 64'(m_fv));
        check_val("sync_error", 64'(sync_error), 64'(m_err));
        check_val("locked", 64'(locked), 64'(m_locked));
        check_val("frame_count", 64'(frame_count), 64'(m_count));
    endtask

    // One clock cycle: drive on the falling edge, check just after the rising edge.
    task automatic step(input bit v, input bit s, input logic [3:0] nib);
        @(negedge clk);
        in_valid   = v;
        frame_sync = s;
        mux_in     = nib;
        @(posedge clk);
        model_step(v, s, nib);
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'($urandom));
    endtask

    task automatic send_frame(input frame_t fr, input int max_gap);
        for (int i = 0; i < F; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            step(1'b1, (i == 0), fr[i]);
        end
    endtask

    task automatic sync_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
    endtask

    function automatic frame_t rand_frame();
        frame_t fr;
        for (int i = 0; i < F; i++) fr[i] = 4'($urandom);
        return fr;
    endfunction

    frame_t fa;
    frame_t fb;
    frame_t fc;
    int     pulses;
    int     k;

    initial begin
        fa = '{4'h4, 4'h3, 4'h2, 4'h1, 4'hD, 4'hC, 4'hB, 4'hA,
               4'hF, 4'h0, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF, 4'hF};
        model_reset();

        // Reset state
        #12;
        check_all();
        reset = 1'b0;
        idle(2);

        // Reference frame at full rate
        send_frame(fa, 0);
        check_val("ref_signals", signals, 64'hFFFF_0F0F_ABCD_1234);
        check_val("ref_count", 64'(frame_count), 64'd1);
        check_val("ref_fv", 64'(frame_valid), 64'd1);
        step(1'b0, 1'b0, 4'h0);
        check_val("ref_fv_drop", 64'(frame_valid), 64'd0);

        // Same frame with idle gaps between nibbles: exactly one pulse
        pulses = 0;
        for (int i = 0; i < F; i++) begin
            k = $urandom_range(0, 5);
            for (int g = 0; g < k; g++) begin
                step(1'b0, 1'b0, 4'($urandom));
                if (frame_valid) pulses++;
            end
            step(1'b1, (i == 0), fa[i]);
            if (frame_valid) pulses++;
        end
        check_val("gap_signals", signals, 64'hFFFF_0F0F_ABCD_1234);
        check_val("gap_pulses", 64'(pulses), 64'd1);

        // Stray nibbles without sync after reset are ignored
        sync_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'($urandom));
        check_val("stray_locked", 64'(locked), 64'd0);
        send_frame(fa, 0);
        check_val("stray_signals", signals, 64'hFFFF_0F0F_ABCD_1234);

        // Frame A, partial frame B, then sync of frame C
        sync_reset();
        fb = rand_frame();
        fc = rand_frame();
        send_frame(fa, 0);
        for (int i = 0; i < 7; i++) step(1'b1, (i == 0), fb[i]);
        step(1'b1, 1'b1, fc[0]);
        check_val("resync_err", 64'(sync_error), 64'd1);
        check_val("resync_hold", signals, 64'hFFFF_0F0F_ABCD_1234);
        for (int i = 1; i < F; i++) step(1'b1, 1'b0, fc[i]);
        check_val("resync_count", 64'(frame_count), 64'd2);

        // Missing sync at a frame boundary drops lock, keeps the published word
        step(1'b1, 1'b0, 4'h7);
        check_val("nosync_err", 64'(sync_error), 64'd1);
        check_val("nosync_locked", 64'(locked), 64'd0);
        idle(1);

        // Asynchronous reset mid-frame after three frames
        sync_reset();
        for (int f = 0; f < 3; f++) send_frame(rand_frame(), 1);
        check_val("pre_async_count", 64'(frame_count), 64'd3);
        for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 4'($urandom));
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_val("async_signals", signals, 64'd0);
        check_val("async_count", 64'(frame_count), 64'd0);
        check_val("async_locked", 64'(locked), 64'd0);
        check_all();
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        send_frame(fa, 0);
        check_val("post_async_count", 64'(frame_count), 64'd1);

        // Randomized traffic: good frames, truncated frames, stray nibbles
        for (int f = 0; f < 60; f++) begin
            case ($urandom_range(0, 5))
                0: begin
                    k = $urandom_range(1, F - 1);
                    fb = rand_frame();
                    for (int i = 0; i < k; i++) begin
                        idle($urandom_range(0, 2));
                        step(1'b1, (i == 0), fb[i]);
                    end
                end
                1: for (int i = 0; i < $urandom_range(1, 3); i++)
                       step(1'b1, 1'b0, 4'($urandom));
                default: send_frame(rand_frame(), $urandom_range(0, 2));
            endcase
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
